// File: rtl/ip_uart_pkg.sv
// Shared definitions for the Z80 I/O-mapped UART: register offsets, status
// bit positions, control bits and the TX/RX state encodings.
package ip_uart_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  localparam int ST_TX_BUSY  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_RX_FULL  = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_FERR  = 6;
  localparam int ST_RX_OVF   = 7;

  localparam int CTRL_TX_CLR  = 0;
  localparam int CTRL_RX_CLR  = 1;
  localparam int CTRL_ERR_CLR = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/ip_uart_fifo.sv
// Byte FIFO with extra-MSB pointers; clear has priority over push/pop and the
// head is presented combinationally from the registered array.
module ip_uart_fifo #(
  parameter int depth_log2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << depth_log2;

  logic [7:0]          mem [DEPTH];
  logic [depth_log2:0] wr_ptr;
  logic [depth_log2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[depth_log2] != rd_ptr[depth_log2]) &&
                   (wr_ptr[depth_log2-1:0] == rd_ptr[depth_log2-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[depth_log2-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !clear && do_push) mem[wr_ptr[depth_log2-1:0]] <= wdata;
  end

endmodule

// File: rtl/ip_uart_fifo_inst.sv
// Z80 I/O-mapped full-duplex 8N1 UART with TX and RX FIFOs.
// state | meaning
// IDLE  | TX: waiting for a FIFO byte / RX: waiting for a falling edge
// START | TX: driving start bit     / RX: half-bit wait, glitch re-check
// DATA  | 8 data bits, LSB first
// STOP  | TX: driving stop bit      / RX: stop sample, push or framing error
module ip_uart_fifo_inst
  import ip_uart_pkg::*;
#(
  parameter int          clk_freq        = 27000000,
  parameter int          uart_freq       = 115200,
  parameter logic [7:0]  io_base         = 8'h10,
  parameter int          fifo_depth_log2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       iorq_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [7:0] a,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       q_en,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int BIT   = clk_freq / uart_freq;
  localparam int HALF  = BIT / 2;
  localparam int CNT_W = (BIT > 1) ? $clog2(BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'((HALF > 0) ? HALF - 1 : 0);

  logic       sel, ff_wr_n, wr_done, rd_pend;
  logic       wr_act, wr_data, wr_ctrl, tx_clr, rx_clr, err_clr, rx_pop;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0] tx_rdata, rx_rdata;
  logic       tx_ovf, rx_ovf, rx_ferr;
  logic [7:0] status, status_nx;
  logic       unused_ctrl_bits;

  assign sel     = !iorq_n && ({a[7:1], 1'b0} == io_base);
  assign wr_act  = enable && sel && !ff_wr_n && !wr_done;
  assign wr_data = wr_act && (a[0] == REG_DATA);
  assign wr_ctrl = wr_act && (a[0] == REG_CTRL);
  assign tx_clr  = wr_ctrl && d[CTRL_TX_CLR];
  assign rx_clr  = wr_ctrl && d[CTRL_RX_CLR];
  assign err_clr = wr_ctrl && d[CTRL_ERR_CLR];
  assign rx_pop  = enable && rd_pend && rd_n;
  assign unused_ctrl_bits = ^d[7:3];

  // One OUT gives one action; one IN of the data port gives one pop, after rd_n rises.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ff_wr_n <= 1'b1;
      wr_done <= 1'b0;
      rd_pend <= 1'b0;
    end else if (enable) begin
      ff_wr_n <= wr_n;
      if (wr_act)       wr_done <= 1'b1;
      else if (ff_wr_n) wr_done <= 1'b0;
      if (rx_pop)
        rd_pend <= 1'b0;
      else if (sel && !rd_n && (a[0] == REG_DATA) && !rx_empty)
        rd_pend <= 1'b1;
    end
  end

  assign q_en = sel && !rd_n;

  always_comb begin
    q = '0;
    if (q_en) begin
      if (a[0] == REG_CTRL) q = status;
      else if (!rx_empty)   q = rx_rdata;
    end
  end

  // ---------------- TX ----------------
  tx_state_t        tx_state, tx_state_nx;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_pop, tx_tick;

  assign tx_tick = (tx_cnt == '0);

  always_comb begin
    tx_state_nx = tx_state;
    tx_pop      = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!tx_empty && !tx_clr) begin
                  tx_pop      = 1'b1;
                  tx_state_nx = TX_START;
                end
      TX_START: if (tx_tick) tx_state_nx = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nx = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_nx = TX_IDLE;
      default:  tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      if (tx_pop) tx_shift <= tx_rdata;
      if (tx_state == TX_IDLE) begin
        tx_cnt <= BIT_M1;
        tx_bit <= '0;
      end else if (tx_tick) begin
        tx_cnt <= BIT_M1;
        if (tx_state == TX_DATA) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
      // Registered line driver: the pin follows the state one clk later.
      uart_tx <= (tx_state == TX_START) ? 1'b0 :
                 (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
    end
  end

  ip_uart_fifo #(.depth_log2(fifo_depth_log2)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_data),
    .pop     (tx_pop),
    .clear   (tx_clr),
    .wdata   (d),
    .rdata   (tx_rdata),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  // ---------------- RX ----------------
  rx_state_t        rx_state, rx_state_nx;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_s1, rx_s2, rx_prev;
  logic             rx_tick, rx_push, rx_ferr_set;

  assign rx_tick = (rx_cnt == '0);

  always_comb begin
    rx_state_nx = rx_state;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_state_nx = RX_START;
      RX_START: if (rx_tick) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (rx_tick) begin
                  rx_state_nx = RX_IDLE;
                  rx_push     = rx_s2;
                  rx_ferr_set = !rx_s2;
                end
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_nx;
      if (rx_state == RX_IDLE) begin
        rx_cnt <= HALF_M1;
        rx_bit <= '0;
      end else if (rx_tick) begin
        rx_cnt <= BIT_M1;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
        end
      end else begin
        rx_cnt <= rx_cnt - 1'b1;
      end
    end
  end

  ip_uart_fifo #(.depth_log2(fifo_depth_log2)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (rx_pop),
    .clear   (rx_clr),
    .wdata   (rx_shift),
    .rdata   (rx_rdata),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  // ---------------- flags and status ----------------
  always_ff @(posedge clk) begin
    if (!reset_n || err_clr) begin
      tx_ovf  <= 1'b0;
      rx_ovf  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      if (wr_data && tx_full && !tx_pop) tx_ovf  <= 1'b1;
      if (rx_push && rx_full && !rx_pop) rx_ovf  <= 1'b1;
      if (rx_ferr_set)                   rx_ferr <= 1'b1;
    end
  end

  always_comb begin
    status_nx              = '0;
    status_nx[ST_TX_BUSY]  = (tx_state != TX_IDLE);
    status_nx[ST_TX_EMPTY] = tx_empty;
    status_nx[ST_TX_FULL]  = tx_full;
    status_nx[ST_RX_VALID] = !rx_empty;
    status_nx[ST_RX_FULL]  = rx_full;
    status_nx[ST_TX_OVF]   = tx_ovf;
    status_nx[ST_RX_FERR]  = rx_ferr;
    status_nx[ST_RX_OVF]   = rx_ovf;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) status <= 8'h02;
    else          status <= status_nx;
  end

endmodule

// File: tb/tb_ip_uart_fifo_inst.sv
// Directed-plus-random bench for ip_uart_fifo_inst with BIT=8 and 4-deep FIFOs;
// a line decoder on uart_tx and a queue model of the RX FIFO supply expectations.
module tb_ip_uart_fifo_inst;

  localparam int BIT   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n, enable, iorq_n, wr_n, rd_n, uart_rx;
  logic [7:0] a, d;
  logic [7:0] q;
  logic       q_en, uart_tx;

  int n_tests = 0;
  int n_fail  = 0;

  ip_uart_fifo_inst #(
    .clk_freq(8), .uart_freq(1), .io_base(8'h10), .fifo_depth_log2(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .iorq_n(iorq_n),
    .wr_n(wr_n), .rd_n(rd_n), .a(a), .d(d), .q(q), .q_en(q_en),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial line decoder: samples each bit at its centre.
  logic [7:0] mon_q[$];
  logic [7:0] mon_byte;
  int         mon_cnt = -1;
  int         mon_k;

  always @(negedge clk) begin
    if (!reset_n) mon_cnt = -1;
    else if (mon_cnt < 0) begin
      if (uart_tx === 1'b0) mon_cnt = 0;
    end else begin
      mon_cnt++;
      if (mon_cnt % BIT == BIT / 2) begin
        mon_k = mon_cnt / BIT;
        if (mon_k == 0) chk("tx_start_bit", {15'd0, uart_tx}, 16'd0);
        else if (mon_k <= 8) mon_byte[mon_k-1] = uart_tx;
        else begin
          chk("tx_stop_bit", {15'd0, uart_tx}, 16'd1);
          mon_q.push_back(mon_byte);
          mon_cnt = -1;
        end
      end
    end
  end

  // Reference model
  logic [7:0] m_rx[$];
  logic [7:0] m_txq[$];
  logic       m_rx_ovf = 0, m_ferr = 0, m_tx_ovf = 0;

  function automatic logic [7:0] exp_status_idle();
    return {m_rx_ovf, m_ferr, m_tx_ovf, m_rx.size() == DEPTH, m_rx.size() != 0,
            1'b0, 1'b1, 1'b0};
  endfunction

  task automatic io_wr(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk); a = addr; d = data; iorq_n = 0; wr_n = 0;
    repeat (3) @(negedge clk);
    iorq_n = 1; wr_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic io_rd(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk); a = addr; iorq_n = 0; rd_n = 0;
    @(negedge clk); data = q;
    chk("q_en_during_read", {15'd0, q_en}, 16'd1);
    @(negedge clk); iorq_n = 1; rd_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_status(input string tag);
    logic [7:0] st;
    io_rd(8'h11, st);
    chk(tag, {8'd0, st}, {8'd0, exp_status_idle()});
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    @(negedge clk); uart_rx = 0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BIT) @(negedge clk);
    uart_rx = 1;
    repeat (2 * BIT) @(negedge clk);
    if (!stop) m_ferr = 1;
    else if (m_rx.size() < DEPTH) m_rx.push_back(b);
    else m_rx_ovf = 1;
  endtask

  // Burst of OUTs starting with the line idle: shifter takes one, FIFO the next DEPTH.
  task automatic tx_burst(input int n, input bit seq);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom);
      io_wr(8'h10, b);
      if (i < DEPTH + 1) m_txq.push_back(b);
      else m_tx_ovf = 1;
    end
  endtask

  task automatic tx_drain(input string tag);
    int t = 0;
    int n = m_txq.size();
    while (mon_q.size() < n && t < n * 120 + 50) begin
      @(negedge clk); t++;
    end
    chk({tag, "_frame_count"}, 16'(mon_q.size()), 16'(n));
    while (m_txq.size() != 0 && mon_q.size() != 0)
      chk({tag, "_byte"}, {8'd0, mon_q.pop_front()}, {8'd0, m_txq.pop_front()});
    m_txq.delete();
    repeat (120) @(negedge clk);
    chk({tag, "_no_extra_frame"}, 16'(mon_q.size()), 16'd0);
    mon_q.delete();
  endtask

  initial begin
    logic [7:0] rd;
    logic [9:0] fr;
    int         lat;
    int         n;

    reset_n = 0; enable = 1; iorq_n = 1; wr_n = 1; rd_n = 1;
    a = 0; d = 0; uart_rx = 1;
    repeat (4) @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    chk("reset_uart_tx", {15'd0, uart_tx}, 16'd1);
    chk("reset_q", {8'd0, q}, 16'd0);
    chk("reset_q_en", {15'd0, q_en}, 16'd0);
    chk_status("reset_status");

    // 0x55 frame: exact shape and start latency
    fr  = {1'b1, 8'h55, 1'b0};
    lat = 0;
    fork
      io_wr(8'h10, 8'h55);
      begin
        do begin
          @(negedge clk); lat++;
        end while (uart_tx !== 1'b0 && lat < 30);
        chk("tx_start_latency", 16'(lat), 16'd5);
        for (int i = 0; i < 10 * BIT; i++) begin
          if (i != 0) @(negedge clk);
          chk("tx_frame_55", {15'd0, uart_tx}, {15'd0, fr[i / BIT]});
        end
        @(negedge clk);
        chk("tx_idle_after_frame", {15'd0, uart_tx}, 16'd1);
      end
    join
    m_txq.push_back(8'h55);
    tx_drain("tx_55");

    // TX full: 0x01..0x06 while busy
    tx_burst(6, 1'b1);
    io_rd(8'h11, rd);
    chk("tx_ovf_bit5", {15'd0, rd[5]}, 16'd1);
    chk("tx_full_bit2", {15'd0, rd[2]}, 16'd1);
    chk("tx_busy_bit0", {15'd0, rd[0]}, 16'd1);
    tx_drain("tx_full");
    chk_status("status_with_tx_ovf");
    io_wr(8'h11, 8'h04); m_tx_ovf = 0;
    chk_status("status_after_err_clear");

    // Random bursts
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 7);
      tx_burst(n, 1'b0);
      tx_drain("tx_rand");
      chk_status("status_after_rand_burst");
      io_wr(8'h11, 8'h04); m_tx_ovf = 0;
    end

    // RX path
    rx_send(8'hA5, 1'b1);
    rx_send(8'h3C, 1'b1);
    io_rd(8'h11, rd);
    chk("rx_valid_bit3", {15'd0, rd[3]}, 16'd1);
    for (int i = 0; i < 2; i++) begin
      io_rd(8'h10, rd);
      chk("rx_data", {8'd0, rd}, {8'd0, m_rx.pop_front()});
    end
    io_rd(8'h11, rd);
    chk("rx_valid_clear_bit3", {15'd0, rd[3]}, 16'd0);
    io_rd(8'h10, rd);
    chk("rx_empty_read_zero", {8'd0, rd}, 16'd0);

    // RX overflow with random bytes
    for (int i = 0; i < DEPTH + 1; i++) rx_send(8'($urandom), 1'b1);
    chk_status("rx_full_ovf_status");
    while (m_rx.size() != 0) begin
      io_rd(8'h10, rd);
      chk("rx_rand_data", {8'd0, rd}, {8'd0, m_rx.pop_front()});
    end
    io_wr(8'h11, 8'h04); m_rx_ovf = 0;
    chk_status("status_after_rx_drain");

    // Framing error
    rx_send(8'($urandom), 1'b0);
    io_rd(8'h11, rd);
    chk("ferr_bit6", {15'd0, rd[6]}, 16'd1);
    chk_status("ferr_status");
    io_wr(8'h11, 8'h04); m_ferr = 0;
    chk_status("ferr_cleared");

    // Glitch
    @(negedge clk); uart_rx = 0;
    repeat (2) @(negedge clk); uart_rx = 1;
    repeat (3 * BIT) @(negedge clk);
    chk_status("glitch_ignored");

    // RX clear
    rx_send(8'($urandom), 1'b1);
    rx_send(8'($urandom), 1'b1);
    io_wr(8'h11, 8'h02); m_rx.delete();
    chk_status("rx_fifo_cleared");

    // TX clear leaves the shifter byte alone
    tx_burst(3, 1'b0);
    io_wr(8'h11, 8'h01);
    while (m_txq.size() > 1) void'(m_txq.pop_back());
    tx_drain("tx_clear");

    // Not selected
    @(negedge clk); a = 8'h10; iorq_n = 1; rd_n = 0;
    @(negedge clk);
    chk("unsel_q", {8'd0, q}, 16'd0);
    chk("unsel_q_en", {15'd0, q_en}, 16'd0);
    a = 8'h12; iorq_n = 0;
    @(negedge clk);
    chk("other_addr_q_en", {15'd0, q_en}, 16'd0);
    iorq_n = 1; rd_n = 1;
    @(negedge clk);

    // Reset mid-frame with a second byte still queued
    io_wr(8'h10, 8'($urandom));
    io_wr(8'h10, 8'($urandom));
    repeat (25) @(negedge clk);
    reset_n = 0;
    @(posedge clk); #1;
    chk("reset_midframe_tx", {15'd0, uart_tx}, 16'd1);
    @(negedge clk);
    reset_n = 1;
    m_txq.delete();
    chk_status("reset_midframe_status");
    for (int i = 0; i < 15 * BIT; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) break;
    end
    chk("no_residual_tx", {15'd0, uart_tx}, 16'd1);
    chk("no_residual_frame", 16'(mon_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
